pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB stage registers).
- Detects load-use and branch-operand hazards in ID.
- Sequences multi-cycle multiply/divide occupancy in EX.
- Runs the data-memory request/ready handshake in MEM.
- Generates the per-stage Stall signals, IF_Flush and PC hold, cascading stalls toward the front of the pipe.

---
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipe: hazard detection, MDU occupancy, DMem handshake.
// Optional saturating stall counters are built when PIPE_STALL_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_IMemReady,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_NeedRs,
  input  logic             ID_NeedRt,
  input  logic             ID_WantRs,
  input  logic             ID_WantRt,
  input  logic             ID_BranchTaken,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RtRd,
  input  logic             EX_MduStart,
  input  logic             MEM_RegWrite,
  input  logic             MEM_MemRead,
  input  logic             MEM_MemWrite,
  input  logic [4:0]       MEM_RtRd,
  input  logic             DMem_Ready,
  output logic             DMem_Req,
  output logic             IF_Stall,
  output logic             ID_Stall,
  output logic             EX_Stall,
  output logic             MEM_Stall,
  output logic             WB_Stall,
  output logic             IF_Flush,
  output logic             PC_Hold,
  output logic             MDU_Busy,
  output logic [CNT_W-1:0] Cnt_LoadUse,
  output logic [CNT_W-1:0] Cnt_Mem,
  output logic [CNT_W-1:0] Cnt_Mdu
);

  typedef enum logic {M_IDLE, M_WAIT} mem_state_e;
  typedef enum logic [1:0] {X_IDLE, X_BUSY, X_DONE} mdu_state_e;

  localparam logic [7:0] MDU_LOAD = 8'(MDU_CYCLES - 1);

  mem_state_e mem_state_q, mem_state_d;
  mdu_state_e mdu_state_q, mdu_state_d;
  logic [7:0] mdu_cnt_q, mdu_cnt_d;
  logic       flush_pend_q, flush_pend_d;

  logic mem_op, mem_stall, mdu_start, mdu_stall, ex_stall;
  logic lu, br, id_stall, flush;

  function automatic logic regMatch(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  assign mem_op    = MEM_MemRead | MEM_MemWrite;
  assign mem_stall = mem_op & ~DMem_Ready;
  assign mdu_start = (mdu_state_q == X_IDLE) & EX_MduStart;
  assign mdu_stall = mdu_start | (mdu_state_q == X_BUSY);
  assign ex_stall  = mdu_stall | mem_stall;

  assign lu = EX_MemRead & EX_RegWrite &
              ((regMatch(EX_RtRd, ID_Rs) & (ID_WantRs | ID_NeedRs)) |
               (regMatch(EX_RtRd, ID_Rt) & (ID_WantRt | ID_NeedRt)));

  assign br = (ID_NeedRs & ((EX_RegWrite & regMatch(EX_RtRd, ID_Rs)) |
                            (MEM_MemRead & MEM_RegWrite & regMatch(MEM_RtRd, ID_Rs)))) |
              (ID_NeedRt & ((EX_RegWrite & regMatch(EX_RtRd, ID_Rt)) |
                            (MEM_MemRead & MEM_RegWrite & regMatch(MEM_RtRd, ID_Rt))));

  assign id_stall = lu | br | ex_stall;
  assign flush    = (ID_BranchTaken | flush_pend_q) & ~id_stall;

  // BUSY lasts MDU_CYCLES-1 cycles: the start cycle is the first stalled cycle.
  always_comb begin
    mem_state_d  = mem_state_q;
    mdu_state_d  = mdu_state_q;
    mdu_cnt_d    = mdu_cnt_q;
    flush_pend_d = flush_pend_q;
    case (mem_state_q)
      M_IDLE:  if (mem_op && !DMem_Ready) mem_state_d = M_WAIT;
      M_WAIT:  if (DMem_Ready) mem_state_d = M_IDLE;
      default: mem_state_d = M_IDLE;
    endcase
    case (mdu_state_q)
      X_IDLE: begin
        if (EX_MduStart) begin
          if (MDU_LOAD == 8'd0) begin
            mdu_state_d = X_DONE;
          end else begin
            mdu_state_d = X_BUSY;
            mdu_cnt_d   = MDU_LOAD;
          end
        end
      end
      X_BUSY: begin
        mdu_cnt_d = mdu_cnt_q - 8'd1;
        if (mdu_cnt_q == 8'd1) mdu_state_d = X_DONE;
      end
      X_DONE:  if (!mem_stall) mdu_state_d = X_IDLE;
      default: mdu_state_d = X_IDLE;
    endcase
    if (flush) flush_pend_d = 1'b0;
    else if (ID_BranchTaken && id_stall) flush_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_state_q  <= M_IDLE;
      mdu_state_q  <= X_IDLE;
      mdu_cnt_q    <= 8'd0;
      flush_pend_q <= 1'b0;
    end else begin
      mem_state_q  <= mem_state_d;
      mdu_state_q  <= mdu_state_d;
      mdu_cnt_q    <= mdu_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign DMem_Req  = rst & (mem_state_q == M_IDLE) & mem_op;
  assign MEM_Stall = rst & mem_stall;
  assign EX_Stall  = rst & ex_stall;
  assign ID_Stall  = rst & id_stall;
  assign IF_Stall  = rst & ~IF_IMemReady;
  assign WB_Stall  = 1'b0;
  assign PC_Hold   = rst & (~IF_IMemReady | id_stall);
  assign IF_Flush  = rst & flush;
  assign MDU_Busy  = rst & ((mdu_state_q != X_IDLE) | mdu_start);

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_lu_q, cnt_mem_q, cnt_mdu_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_lu_q  <= '0;
      cnt_mem_q <= '0;
      cnt_mdu_q <= '0;
    end else begin
      if (lu && !ex_stall && cnt_lu_q != '1) cnt_lu_q <= cnt_lu_q + CNT_W'(1);
      if (mem_stall && cnt_mem_q != '1) cnt_mem_q <= cnt_mem_q + CNT_W'(1);
      if (mdu_stall && !mem_stall && cnt_mdu_q != '1) cnt_mdu_q <= cnt_mdu_q + CNT_W'(1);
    end
  end

  assign Cnt_LoadUse = rst ? cnt_lu_q  : '0;
  assign Cnt_Mem     = rst ? cnt_mem_q : '0;
  assign Cnt_Mdu     = rst ? cnt_mdu_q : '0;
`else
  assign Cnt_LoadUse = '0;
  assign Cnt_Mem     = '0;
  assign Cnt_Mdu     = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MDU_CYCLES=4); counter checks follow PIPE_STALL_CNT_EN.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        IF_IMemReady;
  logic [4:0]  ID_Rs, ID_Rt;
  logic        ID_NeedRs, ID_NeedRt, ID_WantRs, ID_WantRt, ID_BranchTaken;
  logic        EX_RegWrite, EX_MemRead, EX_MduStart;
  logic [4:0]  EX_RtRd;
  logic        MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
  logic [4:0]  MEM_RtRd;
  logic        DMem_Ready;
  logic        DMem_Req, IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall;
  logic        IF_Flush, PC_Hold, MDU_Busy;
  logic [31:0] Cnt_LoadUse, Cnt_Mem, Cnt_Mdu;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_CYCLES(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .IF_IMemReady(IF_IMemReady),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_NeedRs(ID_NeedRs), .ID_NeedRt(ID_NeedRt),
    .ID_WantRs(ID_WantRs), .ID_WantRt(ID_WantRt), .ID_BranchTaken(ID_BranchTaken),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RtRd(EX_RtRd),
    .EX_MduStart(EX_MduStart), .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_MemWrite(MEM_MemWrite), .MEM_RtRd(MEM_RtRd), .DMem_Ready(DMem_Ready),
    .DMem_Req(DMem_Req), .IF_Stall(IF_Stall), .ID_Stall(ID_Stall), .EX_Stall(EX_Stall),
    .MEM_Stall(MEM_Stall), .WB_Stall(WB_Stall), .IF_Flush(IF_Flush), .PC_Hold(PC_Hold),
    .MDU_Busy(MDU_Busy), .Cnt_LoadUse(Cnt_LoadUse), .Cnt_Mem(Cnt_Mem), .Cnt_Mdu(Cnt_Mdu)
  );

  // Return every pipeline input to a quiet, hazard-free value.
  task automatic applyStimulus();
    IF_IMemReady = 1'b1;
    ID_Rs = 5'd0; ID_Rt = 5'd0;
    ID_NeedRs = 1'b0; ID_NeedRt = 1'b0; ID_WantRs = 1'b0; ID_WantRt = 1'b0;
    ID_BranchTaken = 1'b0;
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_RtRd = 5'd0; EX_MduStart = 1'b0;
    MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_MemWrite = 1'b0; MEM_RtRd = 5'd0;
    DMem_Ready = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkCount(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs settle 1 time unit after the edge; outputs are sampled 1 unit later.
  task automatic settle();
    #1;
  endtask

  initial begin
    applyStimulus();
    rst = 1'b0;
    IF_IMemReady = 1'b0;
    #2;
    checkOutput("rst_if_stall", IF_Stall, 1'b0);
    checkOutput("rst_pc_hold", PC_Hold, 1'b0);
    checkOutput("rst_dmem_req", DMem_Req, 1'b0);
    checkOutput("rst_mdu_busy", MDU_Busy, 1'b0);
    checkCount("rst_cnt_mem", Cnt_Mem, 32'd0);
    IF_IMemReady = 1'b1;
    #10 rst = 1'b1;
    nextCycle();

    // Load-use on Rs
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RtRd = 5'd5; ID_Rs = 5'd5; ID_WantRs = 1'b1;
    settle();
    checkOutput("lu_id_stall", ID_Stall, 1'b1);
    checkOutput("lu_pc_hold", PC_Hold, 1'b1);
    checkOutput("lu_ex_stall", EX_Stall, 1'b0);
    nextCycle();
    applyStimulus(); ID_Rs = 5'd5; ID_WantRs = 1'b1;
    settle();
    checkOutput("lu_release", ID_Stall, 1'b0);
    checkOutput("lu_release_pc", PC_Hold, 1'b0);
    nextCycle();

    // Destination r0 never matches
    EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_RtRd = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0;
    ID_WantRs = 1'b1; ID_WantRt = 1'b1;
    settle();
    checkOutput("lu_r0", ID_Stall, 1'b0);
    nextCycle();

    // Branch operand produced by an ALU op in EX
    applyStimulus(); EX_RegWrite = 1'b1; EX_RtRd = 5'd7; ID_Rt = 5'd7; ID_NeedRt = 1'b1;
    settle();
    checkOutput("br_ex_id_stall", ID_Stall, 1'b1);
    checkOutput("br_ex_ex_stall", EX_Stall, 1'b0);
    nextCycle();

    // Branch operand from a load in MEM, single-cycle access
    applyStimulus(); MEM_MemRead = 1'b1; MEM_RegWrite = 1'b1; MEM_RtRd = 5'd9;
    ID_Rs = 5'd9; ID_NeedRs = 1'b1; DMem_Ready = 1'b1;
    settle();
    checkOutput("br_mem_id_stall", ID_Stall, 1'b1);
    checkOutput("single_req", DMem_Req, 1'b1);
    checkOutput("single_mem_stall", MEM_Stall, 1'b0);
    nextCycle();

    // Multi-cycle access: ready after 3 wait cycles
    applyStimulus(); MEM_MemRead = 1'b1;
    for (int i = 0; i < 4; i++) begin
      DMem_Ready = (i == 3);
      settle();
      checkOutput($sformatf("mem_req_c%0d", i), DMem_Req, i == 0);
      checkOutput($sformatf("mem_stall_c%0d", i), MEM_Stall, i < 3);
      checkOutput($sformatf("mem_ex_stall_c%0d", i), EX_Stall, i < 3);
      checkOutput($sformatf("mem_id_stall_c%0d", i), ID_Stall, i < 3);
      nextCycle();
    end
    applyStimulus();

    // MDU occupancy: 4 stalled cycles, then X_DONE
    for (int i = 0; i < 6; i++) begin
      EX_MduStart = (i < 5);
      settle();
      checkOutput($sformatf("mdu_ex_stall_c%0d", i), EX_Stall, i < 4);
      checkOutput($sformatf("mdu_busy_c%0d", i), MDU_Busy, i < 5);
      nextCycle();
    end
    applyStimulus();

`ifdef PIPE_STALL_CNT_EN
    checkCount("cnt_loaduse", Cnt_LoadUse, 32'd1);
    checkCount("cnt_mem", Cnt_Mem, 32'd3);
    checkCount("cnt_mdu", Cnt_Mdu, 32'd4);
`else
    checkCount("cnt_loaduse_off", Cnt_LoadUse, 32'd0);
    checkCount("cnt_mem_off", Cnt_Mem, 32'd0);
    checkCount("cnt_mdu_off", Cnt_Mdu, 32'd0);
`endif

    // MEM wait arriving in X_DONE must hold X_DONE with start ignored
    for (int i = 0; i < 7; i++) begin
      EX_MduStart = (i < 6);
      MEM_MemRead = (i == 4 || i == 5);
      DMem_Ready  = (i == 5);
      settle();
      checkOutput($sformatf("done_hold_ex_stall_c%0d", i), EX_Stall, i < 5);
      checkOutput($sformatf("done_hold_busy_c%0d", i), MDU_Busy, i < 6);
      nextCycle();
    end
    applyStimulus();

    // Unstalled taken branch flushes at once
    ID_BranchTaken = 1'b1;
    settle();
    checkOutput("br_flush_now", IF_Flush, 1'b1);
    nextCycle();
    applyStimulus();
    settle();
    checkOutput("br_flush_once", IF_Flush, 1'b0);
    nextCycle();

    // Taken branch during a 2-cycle stall: flush deferred to release
    for (int i = 0; i < 4; i++) begin
      ID_BranchTaken = (i == 0);
      MEM_MemRead = (i < 3);
      DMem_Ready  = (i == 2);
      settle();
      checkOutput($sformatf("defer_flush_c%0d", i), IF_Flush, i == 2);
      checkOutput($sformatf("defer_id_stall_c%0d", i), ID_Stall, i < 2);
      nextCycle();
    end
    applyStimulus();

    // Instruction memory not ready
    IF_IMemReady = 1'b0;
    settle();
    checkOutput("imem_if_stall", IF_Stall, 1'b1);
    checkOutput("imem_pc_hold", PC_Hold, 1'b1);
    checkOutput("imem_id_stall", ID_Stall, 1'b0);
    nextCycle();
    applyStimulus();

    // Reset asserted in the middle of M_WAIT
    MEM_MemRead = 1'b1; EX_MduStart = 1'b1;
    nextCycle();
    settle();
    checkOutput("wait_req", DMem_Req, 1'b0);
    checkOutput("wait_mem_stall", MEM_Stall, 1'b1);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_mem_stall", MEM_Stall, 1'b0);
    checkOutput("async_ex_stall", EX_Stall, 1'b0);
    checkOutput("async_id_stall", ID_Stall, 1'b0);
    checkOutput("async_pc_hold", PC_Hold, 1'b0);
    checkOutput("async_mdu_busy", MDU_Busy, 1'b0);
    checkCount("async_cnt_mdu", Cnt_Mdu, 32'd0);
    applyStimulus();
    #1 rst = 1'b1;
    nextCycle();
    settle();
    checkOutput("post_rst_no_req", DMem_Req, 1'b0);
    checkOutput("post_rst_busy", MDU_Busy, 1'b0);
    nextCycle();
    MEM_MemWrite = 1'b1; DMem_Ready = 1'b1;
    settle();
    checkOutput("post_rst_new_req", DMem_Req, 1'b1);
    nextCycle();
    applyStimulus();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
